// File: rtl/parking_gate_if.sv
// parking_gate_if
// Bundles every lane-facing signal of the parking_gate barrier controller.
// The parking_gate module connects through the slave modport. The master
// modport is for whatever drives the sensors and reads the barrier and event
// outputs (the occupancy side and the test bench).
// Signal summary (direction as seen by parking_gate):
//   timer_i                  minute of day, 0..1439
//   ent_loop_i / ext_loop_i  vehicle present at the entry / exit barrier
//   ent_uni_card_i / ext_uni_card_i  university card presented at a reader
//   ent_pass_i / ext_pass_i  pass sensor beyond the barrier
//   uni_is_vacated_space_i, is_vacated_space_i  vacancy flags
//   ent_barrier_open_o / ext_barrier_open_o  barrier drive, 1 = open
//   car_entered_o / car_exited_o             one-cycle event pulses
//   is_uni_car_enterd_o / is_uni_car_exited_o  university flag for a pulse
//   ent_reject_o             one-cycle refused-entry pulse
//   reject_cnt_o             wrapping count of refused entries
interface parking_gate_if;
    logic [31:0] timer_i;
    logic        ent_loop_i;
    logic        ext_loop_i;
    logic        ent_uni_card_i;
    logic        ext_uni_card_i;
    logic        ent_pass_i;
    logic        ext_pass_i;
    logic        uni_is_vacated_space_i;
    logic        is_vacated_space_i;
    logic        ent_barrier_open_o;
    logic        ext_barrier_open_o;
    logic        car_entered_o;
    logic        car_exited_o;
    logic        is_uni_car_enterd_o;
    logic        is_uni_car_exited_o;
    logic        ent_reject_o;
    logic [15:0] reject_cnt_o;

    modport master (
        output timer_i, ent_loop_i, ext_loop_i, ent_uni_card_i, ext_uni_card_i,
               ent_pass_i, ext_pass_i, uni_is_vacated_space_i, is_vacated_space_i,
        input  ent_barrier_open_o, ext_barrier_open_o, car_entered_o, car_exited_o,
               is_uni_car_enterd_o, is_uni_car_exited_o, ent_reject_o, reject_cnt_o
    );

    modport slave (
        input  timer_i, ent_loop_i, ext_loop_i, ent_uni_card_i, ext_uni_card_i,
               ent_pass_i, ext_pass_i, uni_is_vacated_space_i, is_vacated_space_i,
        output ent_barrier_open_o, ext_barrier_open_o, car_entered_o, car_exited_o,
               is_uni_car_enterd_o, is_uni_car_exited_o, ent_reject_o, reject_cnt_o
    );
endinterface

// File: rtl/parking_gate.sv
// parking_gate
// Entry/exit lane controller for the car park barriers. Each lane debounces
// its presence loop, makes one decision per car, drives its barrier and emits
// a one-cycle event (with a university flag) once the car has cleared the
// pass sensor. The entry lane admits only inside opening hours and only when
// the occupancy block reports a suitable vacancy; refusals are pulsed and
// counted.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   gate  parking_gate_if slave modport carrying all lane signals
// Every output is a register that follows the lane state of the previous
// cycle, so barrier and event changes appear one cycle after the state moves.
module parking_gate #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPEN_TIMEOUT    = 1000
) (
    input logic           clk,
    input logic           rst,
    parking_gate_if.slave gate
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(OPEN_TIMEOUT) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] TO_LAST  = TW'(OPEN_TIMEOUT);
    localparam logic [31:0]   OPEN_FROM  = 32'd480;
    localparam logic [31:0]   OPEN_UNTIL = 32'd1200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_DECIDE,
        S_OPEN,
        S_PASSING,
        S_DONE,
        S_WAIT_CLEAR,
        S_REJECT
    } lane_state_t;

    lane_state_t     entState_q, extState_q;
    logic [DW-1:0]   entDeb_q, extDeb_q;
    logic [TW-1:0]   entTo_q, extTo_q;
    logic            entUni_q, extUni_q;
    logic            entBarrier_q, extBarrier_q;
    logic            carEntered_q, carExited_q;
    logic            uniEntered_q, uniExited_q;
    logic            entReject_q;
    logic [15:0]     rejectCnt_q;
    logic            admit;

    // Only the value presented while in DECIDE is ever acted upon.
    assign admit = (gate.timer_i >= OPEN_FROM) && (gate.timer_i < OPEN_UNTIL) &&
                   ((gate.ent_uni_card_i && gate.uni_is_vacated_space_i) ||
                    gate.is_vacated_space_i);

    // Entry lane. While both lanes sit in DONE the exit event goes first and
    // this lane waits in DONE, so the two events never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            entState_q   <= S_IDLE;
            entDeb_q     <= '0;
            entTo_q      <= '0;
            entUni_q     <= 1'b0;
            entBarrier_q <= 1'b0;
            carEntered_q <= 1'b0;
            uniEntered_q <= 1'b0;
            entReject_q  <= 1'b0;
            rejectCnt_q  <= '0;
        end else begin
            entBarrier_q <= 1'b0;
            carEntered_q <= 1'b0;
            uniEntered_q <= 1'b0;
            entReject_q  <= 1'b0;
            case (entState_q)
                S_IDLE: begin
                    if (gate.ent_loop_i) begin
                        entState_q <= S_DEBOUNCE;
                        entDeb_q   <= DW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (!gate.ent_loop_i) begin
                        entState_q <= S_IDLE;
                    end else if (entDeb_q == DEB_LAST) begin
                        entState_q <= S_DECIDE;
                    end else begin
                        entDeb_q <= entDeb_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    entUni_q <= gate.ent_uni_card_i;
                    entTo_q  <= '0;
                    entState_q <= admit ? S_OPEN : S_REJECT;
                end
                S_OPEN: begin
                    entBarrier_q <= 1'b1;
                    // A pass seen on the terminal count still counts as a car.
                    if (gate.ent_pass_i) begin
                        entState_q <= S_PASSING;
                    end else if (entTo_q == TO_LAST) begin
                        entState_q <= S_WAIT_CLEAR;
                    end else begin
                        entTo_q <= entTo_q + 1'b1;
                    end
                end
                S_PASSING: begin
                    entBarrier_q <= 1'b1;
                    if (!gate.ent_pass_i) begin
                        entState_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (extState_q != S_DONE) begin
                        carEntered_q <= 1'b1;
                        uniEntered_q <= entUni_q;
                        entState_q   <= S_WAIT_CLEAR;
                    end
                end
                S_REJECT: begin
                    entReject_q <= 1'b1;
                    rejectCnt_q <= rejectCnt_q + 1'b1;
                    entState_q  <= S_WAIT_CLEAR;
                end
                S_WAIT_CLEAR: begin
                    if (!gate.ent_loop_i) begin
                        entState_q <= S_IDLE;
                    end
                end
                default: entState_q <= S_IDLE;
            endcase
        end
    end

    // Exit lane: same sequence as entry but every car is let out at any hour.
    always_ff @(posedge clk) begin
        if (rst) begin
            extState_q   <= S_IDLE;
            extDeb_q     <= '0;
            extTo_q      <= '0;
            extUni_q     <= 1'b0;
            extBarrier_q <= 1'b0;
            carExited_q  <= 1'b0;
            uniExited_q  <= 1'b0;
        end else begin
            extBarrier_q <= 1'b0;
            carExited_q  <= 1'b0;
            uniExited_q  <= 1'b0;
            case (extState_q)
                S_IDLE: begin
                    if (gate.ext_loop_i) begin
                        extState_q <= S_DEBOUNCE;
                        extDeb_q   <= DW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (!gate.ext_loop_i) begin
                        extState_q <= S_IDLE;
                    end else if (extDeb_q == DEB_LAST) begin
                        extState_q <= S_DECIDE;
                    end else begin
                        extDeb_q <= extDeb_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    extUni_q   <= gate.ext_uni_card_i;
                    extTo_q    <= '0;
                    extState_q <= S_OPEN;
                end
                S_OPEN: begin
                    extBarrier_q <= 1'b1;
                    if (gate.ext_pass_i) begin
                        extState_q <= S_PASSING;
                    end else if (extTo_q == TO_LAST) begin
                        extState_q <= S_WAIT_CLEAR;
                    end else begin
                        extTo_q <= extTo_q + 1'b1;
                    end
                end
                S_PASSING: begin
                    extBarrier_q <= 1'b1;
                    if (!gate.ext_pass_i) begin
                        extState_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    carExited_q <= 1'b1;
                    uniExited_q <= extUni_q;
                    extState_q  <= S_WAIT_CLEAR;
                end
                S_WAIT_CLEAR: begin
                    if (!gate.ext_loop_i) begin
                        extState_q <= S_IDLE;
                    end
                end
                default: extState_q <= S_IDLE;
            endcase
        end
    end

    assign gate.ent_barrier_open_o  = entBarrier_q;
    assign gate.ext_barrier_open_o  = extBarrier_q;
    assign gate.car_entered_o       = carEntered_q;
    assign gate.car_exited_o        = carExited_q;
    assign gate.is_uni_car_enterd_o = uniEntered_q;
    assign gate.is_uni_car_exited_o = uniExited_q;
    assign gate.ent_reject_o        = entReject_q;
    assign gate.reject_cnt_o        = rejectCnt_q;

endmodule

// File: tb/tb_parking_gate.sv
// tb_parking_gate
// Directed bench for parking_gate (DEBOUNCE_CYCLES = 4, OPEN_TIMEOUT = 8).
// Inputs change on the falling clock edge and outputs are sampled on the
// falling edge, half a cycle away from the rising edge the design uses.
module tb_parking_gate;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   expRejects;
    int   highCount;
    int   pulseCount;

    parking_gate_if gateIf ();

    parking_gate #(
        .DEBOUNCE_CYCLES (4),
        .OPEN_TIMEOUT    (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .gate (gateIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] t, input logic card,
                                 input logic uniVac, input logic vac);
        gateIf.timer_i                = t;
        gateIf.ent_uni_card_i         = card;
        gateIf.uni_is_vacated_space_i = uniVac;
        gateIf.is_vacated_space_i     = vac;
    endtask

    // One complete entry attempt, from loop rising to the loop clearing.
    task automatic runEntry(input logic [31:0] t, input logic card, input logic uniVac,
                            input logic vac, input logic admit, input string tag);
        applyStimulus(t, card, uniVac, vac);
        gateIf.ent_loop_i = 1'b1;
        repeat (6) tick();
        checkOutput({tag, ".closed_n6"}, 32'(gateIf.ent_barrier_open_o), 0);
        tick();
        checkOutput({tag, ".barrier_n7"}, 32'(gateIf.ent_barrier_open_o), 32'(admit));
        checkOutput({tag, ".reject_n7"}, 32'(gateIf.ent_reject_o), 32'(!admit));
        if (!admit) expRejects++;
        checkOutput({tag, ".reject_cnt"}, 32'(gateIf.reject_cnt_o), 32'(expRejects));
        // The decision is already latched, so these changes must not matter.
        applyStimulus(t, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput({tag, ".reject_n8"}, 32'(gateIf.ent_reject_o), 0);
        if (admit) begin
            gateIf.ent_pass_i = 1'b1;
            repeat (3) tick();
            gateIf.ent_pass_i = 1'b0;
            tick();
            checkOutput({tag, ".entered_early"}, 32'(gateIf.car_entered_o), 0);
            checkOutput({tag, ".barrier_passing"}, 32'(gateIf.ent_barrier_open_o), 1);
            tick();
            checkOutput({tag, ".entered"}, 32'(gateIf.car_entered_o), 1);
            checkOutput({tag, ".uni_flag"}, 32'(gateIf.is_uni_car_enterd_o), 32'(card));
            checkOutput({tag, ".barrier_done"}, 32'(gateIf.ent_barrier_open_o), 0);
            tick();
            checkOutput({tag, ".entered_once"}, 32'(gateIf.car_entered_o), 0);
            checkOutput({tag, ".uni_flag_off"}, 32'(gateIf.is_uni_car_enterd_o), 0);
        end
        gateIf.ent_loop_i = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        expRejects  = 0;
        rst = 1'b1;
        gateIf.timer_i                = '0;
        gateIf.ent_loop_i             = 1'b0;
        gateIf.ext_loop_i             = 1'b0;
        gateIf.ent_uni_card_i         = 1'b0;
        gateIf.ext_uni_card_i         = 1'b0;
        gateIf.ent_pass_i             = 1'b0;
        gateIf.ext_pass_i             = 1'b0;
        gateIf.uni_is_vacated_space_i = 1'b0;
        gateIf.is_vacated_space_i     = 1'b0;
        repeat (3) tick();
        checkOutput("rst.ent_barrier", 32'(gateIf.ent_barrier_open_o), 0);
        checkOutput("rst.ext_barrier", 32'(gateIf.ext_barrier_open_o), 0);
        checkOutput("rst.events", 32'({gateIf.car_entered_o, gateIf.car_exited_o,
                    gateIf.is_uni_car_enterd_o, gateIf.is_uni_car_exited_o,
                    gateIf.ent_reject_o}), 0);
        checkOutput("rst.reject_cnt", 32'(gateIf.reject_cnt_o), 0);
        rst = 1'b0;
        tick();

        $display("[TB] entry admission and opening-hour boundaries");
        runEntry(32'd600,  1'b0, 1'b0, 1'b1, 1'b1, "admit600");
        runEntry(32'd479,  1'b0, 1'b1, 1'b1, 1'b0, "t479");
        runEntry(32'd1200, 1'b0, 1'b1, 1'b1, 1'b0, "t1200");
        runEntry(32'd480,  1'b0, 1'b1, 1'b1, 1'b1, "t480");
        runEntry(32'd1199, 1'b0, 1'b0, 1'b1, 1'b1, "t1199");

        $display("[TB] university card handling");
        runEntry(32'd600, 1'b1, 1'b0, 1'b1, 1'b1, "uni_fallback");
        runEntry(32'd600, 1'b1, 1'b0, 1'b0, 1'b0, "uni_nospace");
        runEntry(32'd600, 1'b1, 1'b1, 1'b0, 1'b1, "uni_space");
        runEntry(32'd600, 1'b0, 1'b1, 1'b0, 1'b0, "nocard_unionly");

        $display("[TB] open timeout");
        applyStimulus(32'd600, 1'b0, 1'b0, 1'b1);
        gateIf.ent_loop_i = 1'b1;
        highCount  = 0;
        pulseCount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gateIf.ent_barrier_open_o) highCount++;
            if (gateIf.car_entered_o) pulseCount++;
        end
        checkOutput("timeout.open_cycles", 32'(highCount), 9);
        checkOutput("timeout.no_event", 32'(pulseCount), 0);
        highCount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gateIf.ent_barrier_open_o) highCount++;
        end
        checkOutput("timeout.no_reopen", 32'(highCount), 0);
        gateIf.ent_loop_i = 1'b0;
        repeat (2) tick();
        runEntry(32'd600, 1'b0, 1'b0, 1'b1, 1'b1, "timeout.next_car");

        $display("[TB] exit lane outside opening hours");
        gateIf.timer_i        = 32'd50;
        gateIf.ext_uni_card_i = 1'b0;
        gateIf.ext_loop_i     = 1'b1;
        repeat (7) tick();
        checkOutput("exit.barrier", 32'(gateIf.ext_barrier_open_o), 1);
        checkOutput("exit.ent_idle", 32'(gateIf.ent_barrier_open_o), 0);
        gateIf.ext_pass_i = 1'b1;
        repeat (3) tick();
        gateIf.ext_pass_i = 1'b0;
        repeat (2) tick();
        checkOutput("exit.exited", 32'(gateIf.car_exited_o), 1);
        checkOutput("exit.uni_flag", 32'(gateIf.is_uni_car_exited_o), 0);
        checkOutput("exit.barrier_done", 32'(gateIf.ext_barrier_open_o), 0);
        gateIf.ext_loop_i = 1'b0;
        repeat (2) tick();

        $display("[TB] simultaneous completion");
        applyStimulus(32'd600, 1'b0, 1'b0, 1'b1);
        gateIf.ext_uni_card_i = 1'b1;
        gateIf.ent_loop_i     = 1'b1;
        gateIf.ext_loop_i     = 1'b1;
        repeat (7) tick();
        checkOutput("both.ent_open", 32'(gateIf.ent_barrier_open_o), 1);
        checkOutput("both.ext_open", 32'(gateIf.ext_barrier_open_o), 1);
        gateIf.ext_uni_card_i = 1'b0;
        gateIf.ent_pass_i     = 1'b1;
        gateIf.ext_pass_i     = 1'b1;
        repeat (3) tick();
        gateIf.ent_pass_i = 1'b0;
        gateIf.ext_pass_i = 1'b0;
        tick();
        checkOutput("both.none_yet", 32'({gateIf.car_entered_o, gateIf.car_exited_o}), 0);
        tick();
        checkOutput("both.T_exited", 32'(gateIf.car_exited_o), 1);
        checkOutput("both.T_uni_exit", 32'(gateIf.is_uni_car_exited_o), 1);
        checkOutput("both.T_entered", 32'(gateIf.car_entered_o), 0);
        tick();
        checkOutput("both.T1_exited", 32'(gateIf.car_exited_o), 0);
        checkOutput("both.T1_entered", 32'(gateIf.car_entered_o), 1);
        checkOutput("both.T1_uni_ent", 32'(gateIf.is_uni_car_enterd_o), 0);
        tick();
        checkOutput("both.T2_quiet", 32'({gateIf.car_entered_o, gateIf.car_exited_o}), 0);
        gateIf.ent_loop_i = 1'b0;
        gateIf.ext_loop_i = 1'b0;
        repeat (2) tick();

        $display("[TB] debounce glitch");
        applyStimulus(32'd600, 1'b0, 1'b1, 1'b1);
        gateIf.ent_loop_i = 1'b1;
        repeat (3) tick();
        gateIf.ent_loop_i = 1'b0;
        highCount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gateIf.ent_barrier_open_o || gateIf.ent_reject_o) highCount++;
        end
        checkOutput("glitch.no_action", 32'(highCount), 0);
        checkOutput("glitch.reject_cnt", 32'(gateIf.reject_cnt_o), 32'(expRejects));

        $display("[TB] reset during passing");
        applyStimulus(32'd600, 1'b0, 1'b0, 1'b1);
        gateIf.ent_loop_i = 1'b1;
        repeat (7) tick();
        gateIf.ent_pass_i = 1'b1;
        repeat (2) tick();
        checkOutput("rstmid.barrier_before", 32'(gateIf.ent_barrier_open_o), 1);
        rst = 1'b1;
        gateIf.ent_pass_i = 1'b0;
        tick();
        checkOutput("rstmid.barrier", 32'(gateIf.ent_barrier_open_o), 0);
        checkOutput("rstmid.no_event", 32'(gateIf.car_entered_o), 0);
        checkOutput("rstmid.reject_cnt", 32'(gateIf.reject_cnt_o), 0);
        expRejects = 0;
        rst = 1'b0;
        pulseCount = 0;
        repeat (6) begin
            tick();
            if (gateIf.car_entered_o) pulseCount++;
        end
        checkOutput("rstmid.no_late_event", 32'(pulseCount), 0);
        checkOutput("rstmid.redebounce_n6", 32'(gateIf.ent_barrier_open_o), 0);
        tick();
        checkOutput("rstmid.redebounce_n7", 32'(gateIf.ent_barrier_open_o), 1);
        gateIf.ent_pass_i = 1'b1;
        repeat (3) tick();
        gateIf.ent_pass_i = 1'b0;
        repeat (2) tick();
        checkOutput("rstmid.entered", 32'(gateIf.car_entered_o), 1);
        gateIf.ent_loop_i = 1'b0;
        repeat (2) tick();
        runEntry(32'd1300, 1'b0, 1'b1, 1'b1, 1'b0, "post_rst_reject");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
